// File: rtl/pulse_period_meter.sv
// Measures the cycle count between successive rising edges of pulse_in.
// Optional running min/max tracking is enabled with PULSE_PERIOD_METER_MINMAX_EN.
module pulse_period_meter #(
  parameter int WIDTH = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             overflow,
  output logic             busy
`ifdef PULSE_PERIOD_METER_MINMAX_EN
  ,
  input  logic             clear_minmax,
  output logic [WIDTH-1:0] min_period,
  output logic [WIDTH-1:0] max_period
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             pulse_edge;

  assign pulse_edge = pulse_in & ~pulse_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    pulse_d  = pulse_in;
    if (!enable) begin
      // Disabling discards any capture that would have happened this cycle.
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          state_d = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (pulse_edge) begin
            count_d = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An edge at the terminal count still wins over overflow.
          if (pulse_edge) begin
            period_d = count_q;
            valid_d  = 1'b1;
            ovf_d    = 1'b0;
            count_d  = CNT_ONE;
          end else if (count_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            count_d = '0;
            state_d = WAIT_FIRST;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      pulse_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      pulse_q  <= pulse_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q != IDLE);

`ifdef PULSE_PERIOD_METER_MINMAX_EN
  logic [WIDTH-1:0] min_q, min_d, max_q, max_d;

  // valid_d marks a capture this cycle, so count_q is the new period.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear_minmax) begin
      min_d = '1;
      max_d = '0;
    end else if (valid_d) begin
      if (count_q < min_q) min_d = count_q;
      if (count_q > max_q) max_d = count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: table of periods plus hand-written corner sequences,
// with a scoreboard of expected strobes (cycle and period) checked by a monitor.
module tb_pulse_period_meter;
  localparam int W = 8;
  localparam logic [W-1:0] ALL1 = '1;

  logic         clock = 1'b0;
  logic         reset, enable, pulse_in;
  logic [W-1:0] period_out;
  logic         period_valid, overflow, busy;
`ifdef PULSE_PERIOD_METER_MINMAX_EN
  logic         clear_minmax;
  logic [W-1:0] min_period, max_period;
`endif

  pulse_period_meter #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .overflow     (overflow),
    .busy         (busy)
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    ,
    .clear_minmax (clear_minmax),
    .min_period   (min_period),
    .max_period   (max_period)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int cyc; logic [W-1:0] period; } exp_t;
  exp_t exp_q[$];

  typedef struct { int gap; bit exp_valid; logic [W-1:0] exp_period; } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every strobe must match the head of the scoreboard in cycle and value.
  always @(negedge clock) begin
    if (period_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("valid_unexpected", period_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("period_out", period_out, e.period);
        chk("overflow_on_valid", overflow, 0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic lows(input int n);
    repeat (n) begin
      step();
      pulse_in = 1'b0;
    end
  endtask

  // One-cycle high pulse; edge cycle is the current cycle, strobe expected next cycle.
  task automatic fire(input bit expect_valid, input logic [W-1:0] per);
    step();
    pulse_in = 1'b1;
    if (expect_valid) exp_q.push_back('{cyc + 1, per});
    step();
    pulse_in = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0,   1'b0, 8'd0};
    vecs[1] = '{50,  1'b1, 8'd50};
    vecs[2] = '{50,  1'b1, 8'd50};
    vecs[3] = '{2,   1'b1, 8'd2};
    vecs[4] = '{3,   1'b1, 8'd3};
    vecs[5] = '{17,  1'b1, 8'd17};
    vecs[6] = '{255, 1'b1, 8'd255};
    vecs[7] = '{4,   1'b1, 8'd4};

    reset = 1'b1; enable = 1'b0; pulse_in = 1'b0;
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    clear_minmax = 1'b0;
`endif
    step(); step();
    chk("rst_period", period_out, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    chk("rst_min", min_period, ALL1);
    chk("rst_max", max_period, 0);
`endif

    // Table of periods, including an edge landing exactly on the terminal count.
    reset = 1'b0; enable = 1'b1;
    lows(3);
    chk("busy_after_enable", busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) lows(vecs[i].gap - 2);
      fire(vecs[i].exp_valid, vecs[i].exp_period);
    end
    lows(3);
    chk("table_drained", exp_q.size(), 0);
    chk("table_overflow", overflow, 0);

    // Level high through reset release is not an edge; first real edge only arms.
    pulse_in = 1'b1; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (20) step();
    chk("held_high_busy", busy, 1);
    chk("held_high_period", period_out, 0);
    lows(2);
    fire(1'b0, '0);
    lows(8);
    fire(1'b1, 8'd10);
    lows(2);
    chk("held_high_drained", exp_q.size(), 0);

    // Overflow with no edge, then recovery.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    lows(2);
    fire(1'b0, '0);
    lows(258);
    chk("ovf_set", overflow, 1);
    chk("ovf_period_hold", period_out, 0);
    chk("ovf_busy_wait_first", busy, 1);
    fire(1'b0, '0);
    lows(3);
    fire(1'b1, 8'd5);
    lows(2);
    chk("ovf_cleared", overflow, 0);
    chk("ovf_period_after", period_out, 5);

    // Enable dropped on the capturing edge: capture discarded, IDLE next cycle.
    lows(5);
    step();
    pulse_in = 1'b1; enable = 1'b0;
    step();
    pulse_in = 1'b0;
    chk("dis_busy", busy, 0);
    chk("dis_period_hold", period_out, 5);
    lows(3);
    enable = 1'b1;
    lows(3);
    fire(1'b0, '0);
    lows(5);
    fire(1'b1, 8'd7);
    lows(2);
    chk("reenable_drained", exp_q.size(), 0);

    // Reset mid-measurement.
    lows(26);
    reset = 1'b1;
    step();
    chk("midrst_period", period_out, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;

`ifdef PULSE_PERIOD_METER_MINMAX_EN
    lows(3);
    fire(1'b0, '0);
    lows(38);
    fire(1'b1, 8'd40);
    lows(23);
    fire(1'b1, 8'd25);
    lows(68);
    fire(1'b1, 8'd70);
    lows(2);
    chk("mm_min", min_period, 25);
    chk("mm_max", max_period, 70);
    clear_minmax = 1'b1;
    step();
    clear_minmax = 1'b0;
    chk("mm_clr_min", min_period, ALL1);
    chk("mm_clr_max", max_period, 0);
    lows(5);
    step();
    pulse_in = 1'b1; clear_minmax = 1'b1;
    exp_q.push_back('{cyc + 1, 8'd10});
    step();
    pulse_in = 1'b0; clear_minmax = 1'b0;
    chk("mm_clr_prio_min", min_period, ALL1);
    chk("mm_clr_prio_max", max_period, 0);
    lows(3);
    fire(1'b1, 8'd5);
    lows(2);
    chk("mm_after_min", min_period, 5);
    chk("mm_after_max", max_period, 5);
`endif

    lows(3);
    chk("final_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
